// File: rtl/rat_ckpt.sv
// Speculative register alias table with branch checkpoints and a committed copy.
// Serves WIDTH rename slots per cycle with in-group bypass; recovers from a checkpoint or the committed map.
module rat_ckpt #(
   parameter int NUM_AREG = 32,
   parameter int PREG_W   = 6,
   parameter int WIDTH    = 2,
   parameter int NUM_CKPT = 4,
   localparam int AREG_W  = $clog2(NUM_AREG),
   localparam int CKPT_W  = $clog2(NUM_CKPT)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [WIDTH-1:0]          src1_is_reg,
   input  logic [WIDTH-1:0]          src2_is_reg,
   input  logic [WIDTH-1:0]          need_to_wb,
   input  logic [WIDTH*AREG_W-1:0]   rs1,
   input  logic [WIDTH*AREG_W-1:0]   rs2,
   input  logic [WIDTH*AREG_W-1:0]   rd,
   output logic [WIDTH*PREG_W-1:0]   rat_prs1,
   output logic [WIDTH*PREG_W-1:0]   rat_prs2,
   output logic [WIDTH*PREG_W-1:0]   rat_prd,
   input  logic [WIDTH-1:0]          rename_valid,
   input  logic [WIDTH*AREG_W-1:0]   rename_addr,
   input  logic [WIDTH*PREG_W-1:0]   rename_data,
   input  logic                      ckpt_alloc_valid,
   output logic                      ckpt_alloc_gnt,
   output logic [CKPT_W-1:0]         ckpt_alloc_id,
   input  logic                      ckpt_release,
   input  logic                      restore_valid,
   input  logic [CKPT_W-1:0]         restore_id,
   input  logic                      flush_valid,
   input  logic [WIDTH-1:0]          commit_valid,
   input  logic [WIDTH*AREG_W-1:0]   commit_areg,
   input  logic [WIDTH*PREG_W-1:0]   commit_preg,
   output logic [CKPT_W:0]           ckpt_count,
   output logic                      ckpt_full
);

   typedef logic [PREG_W-1:0] tag_t;

   localparam logic [CKPT_W:0] PTR_ONE  = (CKPT_W+1)'(1);
   localparam logic [CKPT_W:0] PTR_FULL = (CKPT_W+1)'(NUM_CKPT);

   tag_t spec_map  [NUM_AREG];
   tag_t arch_map  [NUM_AREG];
   tag_t spec_next [NUM_AREG];
   tag_t arch_next [NUM_AREG];
   tag_t snap      [NUM_CKPT][NUM_AREG];

   logic [CKPT_W:0] head, tail, head_next, tail_next, restore_pos;
   logic            full_q;
   logic            do_flush, do_restore, do_alloc, do_release;

   // Older slots in the same group forward their new tag; register 0 never matches.
   function automatic tag_t bypass_read(
      input logic [AREG_W-1:0]       idx,
      input int                      slot,
      input tag_t                    base,
      input logic [WIDTH-1:0]        wv,
      input logic [WIDTH*AREG_W-1:0] wa,
      input logic [WIDTH*PREG_W-1:0] wd
   );
      tag_t t;
      t = base;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < slot && wv[i] && wa[i*AREG_W +: AREG_W] == idx && idx != '0)
            t = wd[i*PREG_W +: PREG_W];
      end
      return t;
   endfunction

   for (genvar j = 0; j < WIDTH; j++) begin : g_read
      logic [AREG_W-1:0] a1, a2, ad;
      assign a1 = rs1[j*AREG_W +: AREG_W];
      assign a2 = rs2[j*AREG_W +: AREG_W];
      assign ad = rd[j*AREG_W +: AREG_W];
      assign rat_prs1[j*PREG_W +: PREG_W] = src1_is_reg[j] ?
         bypass_read(a1, j, spec_map[a1], rename_valid, rename_addr, rename_data) : '0;
      assign rat_prs2[j*PREG_W +: PREG_W] = src2_is_reg[j] ?
         bypass_read(a2, j, spec_map[a2], rename_valid, rename_addr, rename_data) : '0;
      assign rat_prd[j*PREG_W +: PREG_W] = need_to_wb[j] ?
         bypass_read(ad, j, spec_map[ad], rename_valid, rename_addr, rename_data) : '0;
   end

   assign do_flush   = flush_valid;
   assign do_restore = restore_valid & ~flush_valid;
   assign do_alloc   = ckpt_alloc_valid & ~full_q & ~flush_valid & ~restore_valid;
   assign do_release = ckpt_release & (ckpt_count != '0) & ~flush_valid;

   assign ckpt_count     = tail - head;
   assign ckpt_full      = full_q;
   assign ckpt_alloc_gnt = do_alloc;
   assign ckpt_alloc_id  = tail[CKPT_W-1:0];

   // Later slots are applied last so the youngest writer of an entry wins.
   always_comb begin
      spec_next = spec_map;
      arch_next = arch_map;
      for (int i = 0; i < WIDTH; i++) begin
         if (rename_valid[i] && rename_addr[i*AREG_W +: AREG_W] != '0)
            spec_next[rename_addr[i*AREG_W +: AREG_W]] = rename_data[i*PREG_W +: PREG_W];
         if (commit_valid[i] && commit_areg[i*AREG_W +: AREG_W] != '0)
            arch_next[commit_areg[i*AREG_W +: AREG_W]] = commit_preg[i*PREG_W +: PREG_W];
      end
   end

   // The restored entry sits in head's lap if its index is not below head's, else one lap on.
   always_comb begin
      head_next   = head;
      tail_next   = tail;
      restore_pos = (restore_id >= head[CKPT_W-1:0]) ? {head[CKPT_W], restore_id}
                                                     : {~head[CKPT_W], restore_id};
      if (do_flush) begin
         head_next = tail;
      end else begin
         if (do_release)
            head_next = head + PTR_ONE;
         if (do_restore)
            tail_next = restore_pos + PTR_ONE;
         else if (do_alloc)
            tail_next = tail + PTR_ONE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_AREG; i++) begin
            spec_map[i] <= tag_t'(i);
            arch_map[i] <= tag_t'(i);
         end
         head   <= '0;
         tail   <= '0;
         full_q <= 1'b0;
      end else begin
         arch_map <= arch_next;
         if (do_flush)
            spec_map <= arch_next;
         else if (do_restore)
            spec_map <= snap[restore_id];
         else
            spec_map <= spec_next;
         head   <= head_next;
         tail   <= tail_next;
         full_q <= ((tail_next - head_next) == PTR_FULL);
      end
   end

   // Snapshot contents are don't-care until allocated, so they carry no reset.
   always_ff @(posedge clock) begin
      if (do_alloc)
         snap[tail[CKPT_W-1:0]] <= spec_next;
   end

endmodule

// File: doc/rat_ckpt.md
# rat_ckpt

Parametrised speculative register alias table for the backend rename stage, with branch checkpoints and an architectural (committed) copy. It serves WIDTH rename slots per cycle and resolves intra-group dependencies in program order. It restores the speculative map from a checkpoint on branch mispredict, or from the committed map on a full pipeline flush. It sits between decode and rename, and the rename stage drives its write ports.

## Interface
- NUM_AREG, 32, architectural registers; AREG_W = $clog2(NUM_AREG); PREG_W >= AREG_W required
- PREG_W, 6, physical register tag width
- WIDTH, 2, rename/commit slots per cycle (slot 0 oldest)
- NUM_CKPT, 4, checkpoint entries, power of two; CKPT_W = $clog2(NUM_CKPT)
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- src1_is_reg, src2_is_reg, need_to_wb  in  WIDTH  per-slot read enables
- rs1, rs2, rd  in  WIDTH*AREG_W  per-slot architectural indices
- rat_prs1, rat_prs2, rat_prd  out  WIDTH*PREG_W  mapped tags; rat_prd is the old mapping of rd
- rename_valid  in  WIDTH  per-slot map write
- rename_addr  in  WIDTH*AREG_W  architectural destination
- rename_data  in  WIDTH*PREG_W  new physical tag
- ckpt_alloc_valid  in  1  take a checkpoint of this cycle's post-write map
- ckpt_alloc_gnt  out  1  checkpoint taken
- ckpt_alloc_id  out  CKPT_W  id of the entry granted or to be granted (tail)
- ckpt_release  in  1  free the oldest live checkpoint (branch retired)
- restore_valid, restore_id  in  1, CKPT_W  mispredict recovery to checkpoint restore_id
- flush_valid  in  1  recover the speculative map from the committed map
- commit_valid  in  WIDTH  per-slot committed write
- commit_areg, commit_preg  in  WIDTH*AREG_W, WIDTH*PREG_W  committed mapping
- ckpt_count  out  CKPT_W+1  number of live checkpoints
- ckpt_full  out  1  ckpt_count == NUM_CKPT

## Operation
- Storage:
  - spec map [NUM_AREG]
  - arch map [NUM_AREG]
  - snap [NUM_CKPT][NUM_AREG]
  - head and tail pointers, CKPT_W+1 bits each including a wrap bit
- Reset: both maps hold the identity mapping (entry i = i). head = tail = 0. Snapshots are don't-care.
- Reset outputs: ckpt_count 0, ckpt_full 0, ckpt_alloc_gnt 0, ckpt_alloc_id 0. Read outputs follow the identity map.
- Read, combinational:
  - A disabled enable gives tag 0.
  - Otherwise the value is spec[idx], overridden by rename_data of the youngest slot i < j with rename_valid[i] and rename_addr[i] == idx.
  - The same override applies to rat_prd.
- Architectural register 0:
  - Writes with addr 0 to spec or arch are dropped.
  - Reads of register 0 return spec[0], which is always 0.
  - Slot bypass never matches addr 0.
- Spec write: for an entry written by several slots, the youngest (highest slot) wins.
- Commit write: arch map, youngest slot wins. Commit writes apply every cycle, including flush and restore cycles.
- Checkpoint allocation:
  - Condition: ckpt_alloc_valid & ~ckpt_full & ~flush_valid & ~restore_valid.
  - Action: snap[tail] <= the next-state spec map, including this cycle's rename writes; tail++; ckpt_alloc_gnt = 1, combinational.
  - Decode guarantees that a branch is the youngest valid slot of its group.
- Release: ckpt_release with ckpt_count > 0 advances head. Release with count 0 is ignored. Release is honoured in restore cycles but not in flush cycles.
- Restore (restore_valid & ~flush_valid):
  - spec <= snap[restore_id].
  - Tail is set to restore_id + 1. The wrap bit is chosen so the entry stays live, and all younger checkpoints are freed.
  - Rename writes and allocation in that cycle are dropped.
  - restore_id must be live and must not be released in the same cycle; otherwise behaviour is undefined.
- Flush (priority over restore):
  - spec <= the next-state arch map, including same-cycle commits.
  - head <= tail, so all checkpoints are freed.
  - Rename writes, allocation and release are dropped.
- Priority order: flush > restore > rename/alloc. Commit is independent of this order.
- ckpt_count = tail - head (CKPT_W+1-bit subtract). ckpt_full = (count == NUM_CKPT), registered from the pointers.

## Timing
- Reads: 0-cycle combinational from current state plus same-cycle slot bypass. A write in cycle N is visible to reads in cycle N+1.
- Allocation, release, restore and flush take effect at the next edge. Reads during a restore/flush cycle return pre-recovery values.
- Full: an allocation while full is refused even if a release is present in the same cycle. The freed entry is usable in the next cycle.
- Pointer wrap: tail at NUM_CKPT-1 increments to 0 and toggles the wrap bit.
- Asynchronous reset mid-operation returns all state to reset values immediately.

## Test plan
- After reset, WIDTH=2: slot0 rs1=5, slot1 rs2=31 -> prs1=5, prs2=31. An enable of 0 -> tag 0.
- Slot0 renames x3->p40; slot1 reads rs1=3 and rd=3 in the same cycle -> slot1 prs1=40, prd=40. Slot0 prd=3. The next cycle reads x3=40.
- Both slots rename x7 (slot0 p33, slot1 p34) -> x7=34. A rename of x0->p50 -> x0 still 0.
- Rename x4->p41 with alloc (id 0 granted). Rename x4->p42, alloc id 1. Rename x4->p43. Restore id 0 -> next cycle x4=41, count=1, next ckpt_alloc_id=1.
- Allocate 4 checkpoints -> full=1. Alloc plus release in the same cycle -> gnt=0 and count=3. Next cycle alloc -> gnt=1, id=0 (wrap), full=1.
- Commit x9->p60 with flush in the same cycle while spec x9=p61 and 2 checkpoints are live -> next cycle x9=60, count=0. Same-cycle rename and alloc are dropped.
